hub75_scan_ctrl: RTL
====================

# hub75_scan_ctrl

Scan controller for the 32x32 RGB LED panel (1/16 scan, HUB75 connector). It walks the 512-entry frame source `ram_address` space row by row and captures the 48-bit `{bottom, top}` pixel words. It serialises one binary-coded-modulation bit plane at a time into the panel shift registers, then latches and displays each plane for a power-of-two on-time. It sits between the animation/frame source and the panel pins, and is the only block that sequences that source.

## Interface
- `BITS`, 8: bit planes per channel, 1..8; plane p uses channel bit (8-BITS+p).
- `BASE_TICKS`, 16: display clocks for plane 0, ≥1; plane p displays BASE_TICKS<<p clocks.
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  run request; sampled only at plane boundaries.
- `ram_address`  out  9  pixel address `{row[3:0], col[4:0]}` to frame source.
- `ram_data`  in  48  pixel word, valid exactly 1 clk after `ram_address`; [23:0] top half, [47:24] bottom half; each half `{R[7:0],G[7:0],B[7:0]}`.
- `r1`,`g1`,`b1`  out  1 each  top-half serial data.
- `r2`,`g2`,`b2`  out  1 each  bottom-half serial data.
- `sclk`  out  1  panel shift clock.
- `lat`  out  1  panel latch strobe.
- `oe_n`  out  1  panel output enable, active-low.
- `row_sel`  out  4  panel row address (A..D).
- `frame_start`  out  1  1-clk pulse at start of each frame.

## Operation
- States: IDLE, ADDR, LOAD, CLK, BLANK, LATCH, DISPLAY.
- IDLE: `oe_n`=1. If `enable`=1, set row=0, plane=0, col=31, and go to ADDR. Pulse `frame_start` in that first ADDR cycle.
- Per pixel, 3 clks:
  - ADDR: drive `ram_address={row,col}`.
  - LOAD: capture `ram_data` bits for the current plane onto r1/g1/b1 (top) and r2/g2/b2 (bottom), `sclk`=0.
  - CLK: `sclk`=1.
- Columns shift 31 down to 0. After col 0's CLK, go to BLANK.
- `oe_n`=1 throughout ADDR/LOAD/CLK/BLANK/LATCH.
- BLANK: 1 clk, `sclk`=0.
- LATCH: 1 clk, `lat`=1, `row_sel`←row.
- DISPLAY: `oe_n`=0 for BASE_TICKS<<plane clks, then advance:
  - If plane<BITS-1: plane+1, next state ADDR.
  - Else: plane=0, row+1; row wraps 15→0. On wrap, the next ADDR pulses `frame_start`.
  - At every DISPLAY exit, if `enable`=0, go to IDLE instead of ADDR. A restart always begins at row 0, plane 0.
- `enable` falling mid-plane has no effect until that plane's DISPLAY completes.
- Reset values: `ram_address`=0, all r/g/b=0, `sclk`=0, `lat`=0, `oe_n`=1, `row_sel`=0, `frame_start`=0, state IDLE.
- Asserting `rst` mid-operation forces these values immediately, with no waiting for clk.

## Timing
- Frame source latency is exactly 1 clk; no handshake and no stall.
- Plane length is 96 + 2 + (BASE_TICKS<<p) clks.
- Row length is BITS·98 + BASE_TICKS·(2^BITS−1).
- Frame length is 16·(row length).
- `lat` never coincides with `oe_n`=0. `row_sel` changes only in LATCH.
- Data outputs change only in LOAD and are held stable through CLK.
- The DISPLAY counter is $clog2(BASE_TICKS<<(BITS-1))+1 bits wide and unsigned.

## Configuration
- Macro `HUB75_BRIGHTNESS_EN`.
- Defined:
  - Adds input `brightness` [2:0].
  - DISPLAY length is unchanged, but `oe_n`=0 only for the first ((BASE_TICKS<<p)·(brightness+1))>>3 clks, truncated. A result of 0 keeps `oe_n`=1 for the whole window.
  - `brightness` is sampled on DISPLAY entry.
- Undefined: no port; full on-time.

## Structure
- `hub75_pkg` holds:
  - state enum
  - PANEL_COLS=32, HALF_ROWS=16
  - half/channel bit-slice constants: TOP=[23:0], BOT=[47:24], R=[23:16], G=[15:8], B=[7:0].
- Sub-module `hub75_oe_timer`: loads the plane on-time (and brightness when enabled), counts down, and emits `oe_n` and `done`.

## Test plan
- Reset: drop `rst` during DISPLAY → same cycle `oe_n`=1, `lat`=0, `sclk`=0, `row_sel`=0, `ram_address`=0; after release with `enable`=1, first ADDR shows `ram_address`=9'd31 and `frame_start`=1.
- Data path: BITS=8, model returns 48'h0000FF_FF0000 at addr 0, 0 elsewhere → row 0 plane 7, 32nd shifted pixel has r1=1, g1=0, b1=0, r2=0, g2=0, b2=1; all other pixels 0.
- On-time: BITS=3, BASE_TICKS=2 → `oe_n` low for 2, 4, 8 clks in planes 0, 1, 2; `row_sel` 0→1 at the next LATCH.
- Frame period: same config → `frame_start` pulses exactly 4928 clks apart (16·(3·98+14)).
- Enable: deassert `enable` during the SHIFT of row 5 plane 1 → plane 1 completes its 4-clk display, then IDLE with `oe_n`=1; reassert → restart at row 0 plane 0 with `frame_start`.
- Macro on, BASE_TICKS=2, BITS=3:
  - `brightness`=3, plane 2 → 4 clks low inside the 8-clk window.
  - `brightness`=0, plane 0 → `oe_n` stays 1.

Source files
------------

// File: rtl/hub75_pkg.sv
// hub75_pkg: shared types and pixel-word slicing for the HUB75 scan controller.
// Pixel word is {bottom, top}, each half {R,G,B} at 8 bits per channel.
package hub75_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      LOAD,
      CLK,
      BLANK,
      LATCH,
      DISPLAY
   } state_t;

   localparam int PANEL_COLS = 32;
   localparam int HALF_ROWS  = 16;

   localparam int TOP_LSB = 0;
   localparam int TOP_MSB = 23;
   localparam int BOT_LSB = 24;
   localparam int BOT_MSB = 47;
   localparam int R_LSB   = 16;
   localparam int R_MSB   = 23;
   localparam int G_LSB   = 8;
   localparam int G_MSB   = 15;
   localparam int B_LSB   = 0;
   localparam int B_MSB   = 7;

   function automatic logic [23:0] top_half(input logic [47:0] w);
      return w[TOP_MSB:TOP_LSB];
   endfunction

   function automatic logic [23:0] bot_half(input logic [47:0] w);
      return w[BOT_MSB:BOT_LSB];
   endfunction

   function automatic logic [7:0] chan_r(input logic [23:0] h);
      return h[R_MSB:R_LSB];
   endfunction

   function automatic logic [7:0] chan_g(input logic [23:0] h);
      return h[G_MSB:G_LSB];
   endfunction

   function automatic logic [7:0] chan_b(input logic [23:0] h);
      return h[B_MSB:B_LSB];
   endfunction

   function automatic logic chan_bit(
      input logic [7:0] ch,
      input logic [2:0] b
   );
      return ch[b];
   endfunction

endpackage

// File: rtl/hub75_scan_ctrl_if.sv
// hub75_scan_ctrl_if: frame-source bus between the scan controller
// and the pixel store; data trails the address by one clock.
interface hub75_scan_ctrl_if;

   logic [8:0]  ram_address;
   logic [47:0] ram_data;

   modport master (
      output ram_address,
      input  ram_data
   );

   modport slave (
      input  ram_address,
      output ram_data
   );

endinterface

// File: rtl/hub75_oe_timer.sv
// hub75_oe_timer: per-plane display window and output-enable generator.
// With HUB75_BRIGHTNESS_EN the on-time is scaled by (brightness+1)/8.
module hub75_oe_timer
   import hub75_pkg::*;
#(
   parameter int BITS       = 8,
   parameter int BASE_TICKS = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [2:0] plane,
`ifdef HUB75_BRIGHTNESS_EN
   input  logic [2:0] brightness,
`endif
   output logic       oe_n,
   output logic       done
);

   localparam int CW = $clog2(BASE_TICKS << (BITS - 1)) + 1;

   logic [CW-1:0] ticks;
   logic [CW-1:0] on_time;
   logic [CW-1:0] cnt;
   logic [CW-1:0] on_rem;
   logic          active;

   assign ticks = CW'(BASE_TICKS) << plane;

`ifdef HUB75_BRIGHTNESS_EN
   assign on_time = CW'(
      ({3'b000, ticks} * {{CW{1'b0}}, brightness}
       + {3'b000, ticks}) >> 3);
`else
   assign on_time = ticks;
`endif

   assign done = active && (cnt == '0);

   // on_rem counts the low cycles still owed, including the current one
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt    <= '0;
         on_rem <= '0;
         active <= 1'b0;
         oe_n   <= 1'b1;
      end else if (load) begin
         cnt    <= ticks - CW'(1);
         on_rem <= on_time;
         active <= 1'b1;
         oe_n   <= (on_time == '0);
      end else if (active) begin
         if (cnt == '0) begin
            active <= 1'b0;
            on_rem <= '0;
            oe_n   <= 1'b1;
         end else begin
            cnt <= cnt - CW'(1);
            if (on_rem != '0)
               on_rem <= on_rem - CW'(1);
            oe_n <= (on_rem <= CW'(1));
         end
      end
   end

endmodule

// File: rtl/hub75_scan_ctrl.sv
// hub75_scan_ctrl: 32x32 1/16-scan HUB75 sequencer with BCM bit planes.
// Optional macro HUB75_BRIGHTNESS_EN adds a 3-bit global brightness input.
module hub75_scan_ctrl
   import hub75_pkg::*;
#(
   parameter int BITS       = 8,
   parameter int BASE_TICKS = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
`ifdef HUB75_BRIGHTNESS_EN
   input  logic [2:0]        brightness,
`endif
   hub75_scan_ctrl_if.master ram,
   output logic              r1,
   output logic              g1,
   output logic              b1,
   output logic              r2,
   output logic              g2,
   output logic              b2,
   output logic              sclk,
   output logic              lat,
   output logic              oe_n,
   output logic [3:0]        row_sel,
   output logic              frame_start
);

   localparam logic [4:0] COL_LAST = 5'(PANEL_COLS - 1);
   localparam logic [3:0] ROW_LAST = 4'(HALF_ROWS - 1);

   state_t      state;
   logic [3:0]  row;
   logic [2:0]  plane;
   logic [4:0]  col;
   logic [8:0]  addr;
   logic        load;
   logic        done;
   logic        last_plane;
   logic        wrap;
   logic [3:0]  row_next;
   logic [2:0]  bit_sel;
   logic [23:0] top_px;
   logic [23:0] bot_px;

   assign ram.ram_address = addr;

   assign bit_sel    = 3'(8 - BITS) + plane;
   assign last_plane = (plane == 3'(BITS - 1));
   assign row_next   = last_plane ? row + 4'd1 : row;
   assign wrap       = last_plane && (row == ROW_LAST);
   assign top_px     = top_half(ram.ram_data);
   assign bot_px     = bot_half(ram.ram_data);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         row         <= '0;
         plane       <= '0;
         col         <= '0;
         addr        <= '0;
         load        <= 1'b0;
         r1          <= 1'b0;
         g1          <= 1'b0;
         b1          <= 1'b0;
         r2          <= 1'b0;
         g2          <= 1'b0;
         b2          <= 1'b0;
         sclk        <= 1'b0;
         lat         <= 1'b0;
         row_sel     <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         lat         <= 1'b0;
         load        <= 1'b0;
         unique case (state)
            IDLE: begin
               sclk <= 1'b0;
               if (enable) begin
                  row         <= '0;
                  plane       <= '0;
                  col         <= COL_LAST;
                  addr        <= {4'd0, COL_LAST};
                  frame_start <= 1'b1;
                  state       <= ADDR;
               end
            end
            ADDR: begin
               sclk  <= 1'b0;
               state <= LOAD;
            end
            // ram_data answers the address shown during ADDR
            LOAD: begin
               r1    <= chan_bit(chan_r(top_px), bit_sel);
               g1    <= chan_bit(chan_g(top_px), bit_sel);
               b1    <= chan_bit(chan_b(top_px), bit_sel);
               r2    <= chan_bit(chan_r(bot_px), bit_sel);
               g2    <= chan_bit(chan_g(bot_px), bit_sel);
               b2    <= chan_bit(chan_b(bot_px), bit_sel);
               sclk  <= 1'b1;
               state <= CLK;
            end
            CLK: begin
               sclk <= 1'b0;
               if (col == '0) begin
                  state <= BLANK;
               end else begin
                  col   <= col - 5'd1;
                  addr  <= {row, col - 5'd1};
                  state <= ADDR;
               end
            end
            BLANK: begin
               lat     <= 1'b1;
               row_sel <= row;
               load    <= 1'b1;
               state   <= LATCH;
            end
            LATCH: begin
               state <= DISPLAY;
            end
            DISPLAY: begin
               if (done) begin
                  plane <= last_plane ? 3'd0 : plane + 3'd1;
                  row   <= row_next;
                  col   <= COL_LAST;
                  if (enable) begin
                     addr        <= {row_next, COL_LAST};
                     frame_start <= wrap;
                     state       <= ADDR;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   hub75_oe_timer #(
      .BITS       (BITS),
      .BASE_TICKS (BASE_TICKS)
   ) u_oe (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .plane      (plane),
`ifdef HUB75_BRIGHTNESS_EN
      .brightness (brightness),
`endif
      .oe_n       (oe_n),
      .done       (done)
   );

   lat_dark_a: assert property (
      @(posedge clk) disable iff (!rst) lat |-> oe_n
   );

endmodule
